// File: rtl/key_debounce.sv
// key_debounce: multi-key debouncer and press encoder.
//
// Each raw key input passes through a two-flop synchronizer and then a
// per-key FSM (Released / PressChk / Pressed / ReleaseChk). A new level is
// accepted only once it has held for StableTicks enable ticks. All outputs
// are registered. They follow the FSM state by one clock.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   enable_in_i      debounce sample tick (one clk wide, or held high)
//   keys_raw_i       raw asynchronous key inputs, active-high
//   key_level_o      debounced key levels
//   press_pulse_o    one-clk pulse per accepted press
//   release_pulse_o  one-clk pulse per accepted release
//   key_strobe_o     one-clk pulse when any key was pressed
//   key_code_o       lowest pressed key index, valid with key_strobe_o
module key_debounce #(
  parameter int unsigned NKeys       = 4,
  parameter int unsigned StableTicks = 4,
  parameter int unsigned CodeW       = (NKeys > 1) ? $clog2(NKeys) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_in_i,
  input  logic [NKeys-1:0] keys_raw_i,
  output logic [NKeys-1:0] key_level_o,
  output logic [NKeys-1:0] press_pulse_o,
  output logic [NKeys-1:0] release_pulse_o,
  output logic             key_strobe_o,
  output logic [CodeW-1:0] key_code_o
);

  localparam int unsigned CntW = $clog2(StableTicks + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressChk,
    StPressed,
    StReleaseChk
  } state_e;

  // Synchronizer
  logic [NKeys-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-key FSM state register
  state_e          state_q [NKeys];
  state_e          state_d [NKeys];
  logic [CntW-1:0] cnt_q   [NKeys];
  logic [CntW-1:0] cnt_d   [NKeys];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NKeys); i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NKeys); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic. Entering a CHK state ignores enable_in_i, so the entry
  // cycle is never counted as a tick.
  always_comb begin
    for (int i = 0; i < int'(NKeys); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StReleased: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressChk;
            cnt_d[i]   = '0;
          end
        end
        StPressChk: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else if (enable_in_i) begin
            if (cnt_q[i] == CntLast) begin
              state_d[i] = StPressed;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        StPressed: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleaseChk;
            cnt_d[i]   = '0;
          end
        end
        StReleaseChk: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (enable_in_i) begin
            if (cnt_q[i] == CntLast) begin
              state_d[i] = StReleased;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output logic. The level only changes on PressChk->Pressed and
  // ReleaseChk->Released, so its edges are exactly the press/release events;
  // a bounce back from ReleaseChk to Pressed keeps the level high.
  logic [NKeys-1:0] level_d, press_d, release_d;
  logic             strobe_d;
  logic [CodeW-1:0] code_d;
  logic [NKeys-1:0] key_level_q, press_pulse_q, release_pulse_q;
  logic             key_strobe_q;
  logic [CodeW-1:0] key_code_q;

  always_comb begin
    level_d = '0;
    for (int i = 0; i < int'(NKeys); i++) begin
      level_d[i] = (state_q[i] == StPressed) || (state_q[i] == StReleaseChk);
    end
    press_d   = level_d & ~key_level_q;
    release_d = ~level_d & key_level_q;
    strobe_d  = |press_d;
    code_d    = key_code_q;
    // Descending scan so the lowest pressed index wins.
    for (int i = int'(NKeys) - 1; i >= 0; i--) begin
      if (press_d[i]) begin
        code_d = CodeW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_level_q     <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      key_strobe_q    <= 1'b0;
      key_code_q      <= '0;
    end else begin
      key_level_q     <= level_d;
      press_pulse_q   <= press_d;
      release_pulse_q <= release_d;
      key_strobe_q    <= strobe_d;
      key_code_q      <= code_d;
    end
  end

  assign key_level_o     = key_level_q;
  assign press_pulse_o   = press_pulse_q;
  assign release_pulse_o = release_pulse_q;
  assign key_strobe_o    = key_strobe_q;
  assign key_code_o      = key_code_q;

endmodule

// File: tb/tb_key_debounce.sv
// Randomized self-checking bench for key_debounce, compared each cycle
// against a behavioural model of the debounce rules.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int ST = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [NK-1:0] raw = '0;
  logic [NK-1:0] level, press, rel;
  logic          strobe;
  logic [CW-1:0] code;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_mode = 0;  // 0: low, 1: high, 2: every 10 clks, 3: random

  always #5 clk = ~clk;

  key_debounce #(
    .NKeys      (NK),
    .StableTicks(ST),
    .CodeW      (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_in_i    (en),
    .keys_raw_i     (raw),
    .key_level_o    (level),
    .press_pulse_o  (press),
    .release_pulse_o(rel),
    .key_strobe_o   (strobe),
    .key_code_o     (code)
  );

  // Reference model: accepted level per key, whether the synchronized input
  // currently disagrees with it, and how many ticks that disagreement has seen.
  logic [NK-1:0] m_s1, m_s2, m_acc;
  logic [NK-1:0] m_pend;
  int            m_ticks [NK];
  logic [NK-1:0] e_level, e_press, e_rel;
  logic          e_strobe;
  logic [CW-1:0] e_code;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_acc = '0; m_pend = '0;
    for (int i = 0; i < NK; i++) m_ticks[i] = 0;
    e_level = '0; e_press = '0; e_rel = '0; e_strobe = 1'b0; e_code = '0;
  endtask

  task automatic model_update();
    e_press  = m_acc & ~e_level;
    e_rel    = ~m_acc & e_level;
    e_level  = m_acc;
    e_strobe = |e_press;
    if (e_strobe) begin
      for (int i = NK - 1; i >= 0; i--) if (e_press[i]) e_code = CW'(i);
    end
    for (int i = 0; i < NK; i++) begin
      if (m_s2[i] != m_acc[i]) begin
        if (!m_pend[i]) begin
          m_pend[i]  = 1'b1;
          m_ticks[i] = 0;
        end else if (en) begin
          m_ticks[i]++;
          if (m_ticks[i] == ST) begin
            m_acc[i]  = m_s2[i];
            m_pend[i] = 1'b0;
          end
        end
      end else begin
        m_pend[i] = 1'b0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check_all();
    check_eq("key_level", 32'(level), 32'(e_level));
    check_eq("press_pulse", 32'(press), 32'(e_press));
    check_eq("release_pulse", 32'(rel), 32'(e_rel));
    check_eq("key_strobe", 32'(strobe), 32'(e_strobe));
    check_eq("key_code", 32'(code), 32'(e_code));
  endtask

  // One clock: enable driven per mode, model follows the edge, check at negedge.
  task automatic step();
    case (en_mode)
      0: en = 1'b0;
      1: en = 1'b1;
      2: en = (cyc % 10 == 0);
      default: en = ($urandom_range(0, 2) == 0);
    endcase
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int n, cnt_press, cnt_rel, cnt_strobe;
  logic [NK-1:0] seen_press;
  logic [CW-1:0] seen_code;

  initial begin
    model_reset();
    #12;
    check_all();  // reset state
    @(negedge clk);
    rst_n = 1'b1;

    // Fast-mode press latency on key 1
    en_mode = 1;
    run(3);
    raw = 4'b0010;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (press[1] && n == 0) n = k;
    end
    check_eq("fast_press_latency", 32'(n), 32'd8);
    raw = '0;
    run(12);

    // Bounce rejection on key 0 with a tick every 10 clks
    en_mode = 2;
    cnt_press = 0;
    for (int r = 0; r < 4; r++) begin
      raw[0] = 1'b1;
      for (int k = 0; k < 25; k++) begin step(); cnt_press += int'(press[0]); end
      raw[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin step(); cnt_press += int'(press[0]); end
    end
    check_eq("bounce_no_press", 32'(cnt_press), 32'd0);
    raw[0] = 1'b1;
    for (int k = 0; k < 80; k++) begin step(); cnt_press += int'(press[0]); end
    check_eq("bounce_one_press", 32'(cnt_press), 32'd1);
    raw[0] = 1'b0;
    run(80);

    // Release of key 2 with a short low glitch first
    en_mode = 1;
    raw[2] = 1'b1;
    run(15);
    cnt_rel = 0; cnt_strobe = 0;
    raw[2] = 1'b0;
    for (int k = 0; k < 2; k++) begin step(); cnt_rel += int'(rel[2]); end
    raw[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin step(); cnt_rel += int'(rel[2]); end
    check_eq("glitch_no_release", 32'(cnt_rel), 32'd0);
    raw[2] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      cnt_rel += int'(rel[2]);
      cnt_strobe += int'(strobe);
      if (rel[2]) check_eq("release_level_low", 32'(level[2]), 32'd0);
    end
    check_eq("release_once", 32'(cnt_rel), 32'd1);
    check_eq("release_no_strobe", 32'(cnt_strobe), 32'd0);

    // Simultaneous press
    raw = 4'b1010;
    seen_press = '0; seen_code = '0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (strobe) begin seen_press = press; seen_code = code; end
    end
    check_eq("simul_press", 32'(seen_press), 32'hA);
    check_eq("simul_code", 32'(seen_code), 32'd1);
    raw = '0;
    run(15);

    // Reset while key 3 is in PRESS_CHK with cnt=2
    raw[3] = 1'b1;
    run(5);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("reset_async_level", 32'(level), 32'd0);
    run(2);
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (press[3] && n == 0) n = k;
    end
    check_eq("post_reset_latency", 32'(n), 32'd8);
    raw = '0;
    run(15);

    // No enable: held key never accepted
    en_mode = 0;
    raw = 4'b0001;
    cnt_strobe = 0;
    for (int k = 0; k < 60; k++) begin step(); cnt_strobe += int'(strobe) + int'(level[0]); end
    check_eq("no_enable_quiet", 32'(cnt_strobe), 32'd0);
    raw = '0;
    run(5);

    // Randomized traffic under varying enable modes
    for (int blk = 0; blk < 12; blk++) begin
      en_mode = 1 + (blk % 3);
      for (int k = 0; k < 200; k++) begin
        for (int i = 0; i < NK; i++) if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-key debouncer and press encoder for the calculator keypad and push-buttons.
- Sits directly downstream of the enable generator. Its enable_in is the periodic enable_out tick, which sets the debounce sample rate.
- Produces clean per-key levels, single-clock press/release pulses, and an encoded key strobe for the RPN input logic.

Parameters:
- N_KEYS, 4: number of independent raw key inputs; must be >= 1.
- STABLE_TICKS, 4: consecutive enable ticks a new input level must persist before it is accepted; must be >= 1.
- CODE_W, $clog2(N_KEYS) (minimum 1): width of key_code.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- enable_in, input, 1: sample tick from the enable generator; may be one clk wide or held high permanently.
- keys_raw, input, N_KEYS: asynchronous raw key inputs, active-high.
- key_level, output, N_KEYS: debounced key state.
- press_pulse, output, N_KEYS: one-clk pulse per accepted press.
- release_pulse, output, N_KEYS: one-clk pulse per accepted release.
- key_strobe, output, 1: one-clk pulse; some key was pressed this cycle.
- key_code, output, CODE_W: index of the pressed key, valid while key_strobe=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - all synchronizer flops = 0, all FSMs = RELEASED, all counters = 0.
  - key_level, press_pulse, release_pulse, key_strobe, key_code = 0.
- Synchronizer: two flops per key, clocked every clk. s[i] is the second-stage output; the FSM sees only s[i].
- Per-key FSM with counter cnt, width $clog2(STABLE_TICKS+1). Every transition takes effect on clk.
  - RELEASED: s=1 -> PRESS_CHK, cnt=0.
  - PRESS_CHK:
    - s=0 on any clk (tick or not) -> RELEASED, cnt=0.
    - enable_in=1 and s=1: if cnt==STABLE_TICKS-1 -> PRESSED, else cnt+1.
  - PRESSED: s=0 -> RELEASE_CHK, cnt=0.
  - RELEASE_CHK:
    - s=1 on any clk -> PRESSED, cnt=0. No pulse is generated.
    - enable_in=1 and s=0: if cnt==STABLE_TICKS-1 -> RELEASED, else cnt+1.
  - The cycle in which the FSM enters a CHK state never counts as a tick, even if enable_in=1 in that cycle.
- Outputs are all registered:
  - key_level[i] = 1 while the FSM is in PRESSED or RELEASE_CHK.
  - press_pulse[i] is high for exactly one clk, in the cycle after the PRESS_CHK->PRESSED transition. key_level[i] rises in that same cycle.
  - release_pulse[i] behaves the same way for RELEASE_CHK->RELEASED; key_level[i] falls in the same cycle.
- Encoder:
  - key_strobe = OR of press_pulse, aligned with it.
  - key_code = lowest index i with press_pulse[i]=1 in that cycle. Higher-index simultaneous presses appear only on press_pulse.
  - key_code holds its last value when key_strobe=0.
- enable_in permanently high (fast mode): the debounce window is STABLE_TICKS clks.
- The counter never wraps. It is bounded to 0..STABLE_TICKS-1 in every state.
- Keys are fully independent. Simultaneous transitions on different keys are all processed in the same cycle.
- Reset mid-operation:
  - In-flight pulses are dropped and no release pulse is emitted.
  - A key still held when reset deasserts goes through the normal press sequence and produces one press_pulse.
- keys_raw glitches shorter than two clks may be missed by the synchronizer. This is acceptable.

Test Plan:
1. Fast-mode press: enable_in=1, STABLE_TICKS=4; keys_raw[1] rises and holds -> press_pulse[1], key_strobe=1, key_code=1 and key_level[1]=1 all appear together, 8 clks after the first clk edge that samples the high input. press_pulse[1] is high for 1 clk.
2. Bounce rejection: enable_in pulses every 10 clks; keys_raw[0] toggles high for 25 clks, low for 5, repeated 4 times, then holds high -> no press_pulse during bouncing; exactly one press_pulse[0] after 4 stable ticks of steady high.
3. Release: hold key 2 pressed, then drop it and keep it low -> release_pulse[2] once, key_level[2]=0 in the same cycle, no key_strobe. A low glitch shorter than 4 ticks while pressed produces no pulses.
4. Simultaneous press: keys_raw=4'b1010 driven in one cycle -> press_pulse=4'b1010 in one cycle, key_strobe=1, key_code=1.
5. Reset mid-debounce: assert reset while key 3 is in PRESS_CHK with cnt=2 and hold the key high -> all outputs 0 immediately (asynchronous). After reset deasserts, press_pulse[3] arrives 8 clks later in fast mode.
6. Slow tick with no enable: enable_in=0 throughout, key held -> FSM stays in PRESS_CHK and no outputs ever assert.
